ramp_adc_ctrl: RTL and testbench

Multi-channel ramp-compare ADC controller. It generates a stepped ramp code, drives it out as PWM into the external RC DAC, and watches CHANNELS external comparators. For each channel it latches the ramp code at which that comparator first drops. Unlike the single-channel sawtooth generator, it adds:
- parametrised channel count
- a DAC settle phase
- early sweep termination
- over-range flags
- a single-shot or continuous mode with a result_valid strobe

---
 rtl/ramp_adc_pkg.sv | 18 +
 rtl/pwm_core.sv | 35 +++
 rtl/ramp_adc_ctrl.sv | 145 ++++++++++++++
 tb/tb_ramp_adc_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/ramp_adc_pkg.sv
// rtl/ramp_adc_pkg.sv - shared types and helpers for the ramp-compare ADC controller
package ramp_adc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RAMP   = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Clocks from start accept to the result_valid cycle for a sweep that runs to full scale:
  // one settle step plus 2**width ramp steps, each step_periods PWM periods long.
  function automatic int unsigned sweep_latency(input int unsigned width,
                                                input int unsigned step_periods);
    return (1 + (1 << width)) * step_periods * (1 << width);
  endfunction

endpackage

// File: rtl/pwm_core.sv
// rtl/pwm_core.sv - free-running PWM counter with registered compare output and wrap pulse
module pwm_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [WIDTH-1:0] code,
  output logic             pwm_out,
  output logic             wrap
);

  logic [WIDTH-1:0] cnt;

  // Period counter; clear realigns the period so a new sweep starts on a period boundary.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Registered compare: high for 'code' clocks out of every 2**WIDTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_out <= 1'b0;
    end else begin
      pwm_out <= (cnt < code);
    end
  end

  assign wrap = &cnt;

endmodule

// File: rtl/ramp_adc_ctrl.sv
// rtl/ramp_adc_ctrl.sv - multi-channel ramp-compare ADC controller
module ramp_adc_ctrl
  import ramp_adc_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CHANNELS     = 4,
  parameter int STEP_PERIODS = 4,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      mode,
  input  logic [CHANNELS-1:0]       cmp_in,
  output logic                      pwm_out,
  output logic [WIDTH-1:0]          ramp_code,
  output logic                      busy,
  output logic [CHANNELS*WIDTH-1:0] result,
  output logic                      result_valid,
  output logic [CHANNELS-1:0]       overrange
);

  localparam int STEP_W = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEP_PERIODS - 1);
  localparam logic [WIDTH-1:0]  CODE_MAX  = {WIDTH{1'b1}};

  state_t state, state_nxt;

  logic [CHANNELS-1:0]       sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0]       cmp_s;
  logic [STEP_W-1:0]         step_cnt;
  logic                      wrap;
  logic                      tick;
  logic                      start_acc;
  logic                      enter_settle;
  logic [CHANNELS-1:0]       captured, cap_nxt;
  logic [CHANNELS-1:0]       cap_ovr, ovr_nxt;
  logic [CHANNELS*WIDTH-1:0] cap_code, code_nxt;
  logic                      all_cap;

  assign cmp_s        = sync_q[SYNC_STAGES-1];
  assign start_acc    = (state == IDLE) && start;
  assign enter_settle = (state_nxt == SETTLE) && (state != SETTLE);
  assign tick         = wrap && (step_cnt == LAST_STEP);

  pwm_core #(.WIDTH(WIDTH)) u_pwm (
    .clk     (clk),
    .reset   (reset),
    .clear   (start_acc),
    .code    (ramp_code),
    .pwm_out (pwm_out),
    .wrap    (wrap)
  );

  // Comparator synchroniser chain; only the last stage is ever looked at.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= cmp_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  // Counts PWM periods within one ramp step; restarts with each new sweep from IDLE.
  always_ff @(posedge clk) begin
    if (reset || start_acc) begin
      step_cnt <= '0;
    end else if (wrap) begin
      step_cnt <= (step_cnt == LAST_STEP) ? '0 : step_cnt + 1'b1;
    end
  end

  // Per-channel capture decision for the current step, applied only on a RAMP tick.
  always_comb begin
    cap_nxt  = captured;
    ovr_nxt  = cap_ovr;
    code_nxt = cap_code;
    for (int i = 0; i < CHANNELS; i++) begin
      if (!captured[i]) begin
        if (!cmp_s[i]) begin
          code_nxt[i*WIDTH +: WIDTH] = ramp_code;
          cap_nxt[i]                 = 1'b1;
        end else if (ramp_code == CODE_MAX) begin
          code_nxt[i*WIDTH +: WIDTH] = CODE_MAX;
          ovr_nxt[i]                 = 1'b1;
          cap_nxt[i]                 = 1'b1;
        end
      end
    end
    all_cap = &cap_nxt;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_nxt    = state;
    busy         = (state != IDLE);
    result_valid = (state == DONE);
    case (state)
      IDLE:    if (start) state_nxt = SETTLE;
      SETTLE:  if (tick) state_nxt = RAMP;
      RAMP:    if (tick && all_cap) state_nxt = DONE;
      DONE:    state_nxt = mode ? SETTLE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Ramp code, capture shadows and the published result/overrange registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ramp_code <= '0;
      captured  <= '0;
      cap_ovr   <= '0;
      cap_code  <= '0;
      result    <= '0;
      overrange <= '0;
    end else if (enter_settle) begin
      ramp_code <= '0;
      captured  <= '0;
      cap_ovr   <= '0;
      cap_code  <= '0;
    end else if ((state == RAMP) && tick) begin
      captured <= cap_nxt;
      cap_ovr  <= ovr_nxt;
      cap_code <= code_nxt;
      if (all_cap) begin
        ramp_code <= '0;
        result    <= code_nxt;
        overrange <= ovr_nxt;
      end else begin
        ramp_code <= ramp_code + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ramp_adc_ctrl.sv
// tb/tb_ramp_adc_ctrl.sv - self-checking bench for ramp_adc_ctrl
module tb_ramp_adc_ctrl;

  localparam int W    = 4;
  localparam int CH   = 2;
  localparam int SP   = 1;
  localparam int SS   = 2;
  localparam int STEP = (1 << W) * SP;
  localparam int MAXC = (1 << W) - 1;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic            mode;
  logic [CH-1:0]   cmp_in;
  logic            pwm_out;
  logic [W-1:0]    ramp_code;
  logic            busy;
  logic [CH*W-1:0] result;
  logic            result_valid;
  logic [CH-1:0]   overrange;

  int n_cmp = 0;
  int n_bad = 0;
  int level [CH];
  bit plant_en = 1'b0;
  bit duty_en  = 1'b0;
  int prev_code = 0;
  int hi_cnt    = 0;

  always #5 clk = ~clk;

  ramp_adc_ctrl #(
    .WIDTH(W), .CHANNELS(CH), .STEP_PERIODS(SP), .SYNC_STAGES(SS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .mode         (mode),
    .cmp_in       (cmp_in),
    .pwm_out      (pwm_out),
    .ramp_code    (ramp_code),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .overrange    (overrange)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: comparator plant (input trips once the DAC code reaches its level) and duty monitor.
  task automatic clk_step();
    @(negedge clk);
    if (plant_en) begin
      for (int i = 0; i < CH; i++) cmp_in[i] = (int'(ramp_code) < level[i]);
    end
    if (int'(ramp_code) != prev_code) begin
      if (duty_en) check("pwm_duty", hi_cnt, prev_code);
      prev_code = int'(ramp_code);
      hi_cnt    = 0;
    end
    if (pwm_out) hi_cnt++;
  endtask

  // Level > MAXC means the comparator never trips.
  task automatic do_sweep(input int lv0, input int lv1, input bit cont, input int nsw,
                          input bit poke, input string tag);
    int exp_r [CH];
    logic [CH-1:0] exp_o;
    int m, lat, strobes, last_cyc, busy_low, extra;
    bit fin;
    level[0] = lv0;
    level[1] = lv1;
    m = 0;
    for (int i = 0; i < CH; i++) begin
      exp_r[i] = (level[i] > MAXC) ? MAXC : level[i];
      exp_o[i] = (level[i] > MAXC);
      if (exp_r[i] > m) m = exp_r[i];
    end
    lat = STEP * (2 + m);
    mode  = cont;
    start = 1'b1;
    clk_step();
    start = 1'b0;
    check({tag, "_busy_on"}, busy, 1);
    strobes  = 0;
    last_cyc = 0;
    busy_low = 0;
    fin      = 1'b0;
    for (int cyc = 1; cyc <= nsw * lat + 8 && !fin; cyc++) begin
      start = (poke && cyc == 40);
      if (cont && strobes == nsw - 1 && strobes > 0 && cyc - last_cyc >= 2) mode = 1'b0;
      clk_step();
      if (!busy) busy_low++;
      if (result_valid) begin
        strobes++;
        check({tag, "_latency"}, cyc - last_cyc, lat);
        last_cyc = cyc;
        for (int i = 0; i < CH; i++) check({tag, "_result"}, result[i*W +: W], exp_r[i]);
        check({tag, "_overrange"}, overrange, exp_o);
        if (strobes == nsw) begin
          clk_step();
          check({tag, "_busy_off"}, busy, 0);
          fin = 1'b1;
        end
      end
    end
    start = 1'b0;
    check({tag, "_strobes"}, strobes, nsw);
    check({tag, "_busy_held"}, busy_low, 0);
    extra = 0;
    for (int k = 0; k < 3 * STEP; k++) begin
      clk_step();
      if (result_valid || busy) extra++;
    end
    check({tag, "_quiet"}, extra, 0);
    check({tag, "_result_hold0"}, result[0 +: W], exp_r[0]);
    check({tag, "_result_hold1"}, result[W +: W], exp_r[1]);
  endtask

  initial begin
    int strobes;
    reset  = 1'b1;
    start  = 1'($urandom_range(0, 1));
    mode   = 1'($urandom_range(0, 1));
    cmp_in = CH'($urandom);
    clk_step();
    check("rst_pwm_out", pwm_out, 0);
    check("rst_ramp_code", ramp_code, 0);
    check("rst_busy", busy, 0);
    check("rst_result", result, 0);
    check("rst_result_valid", result_valid, 0);
    check("rst_overrange", overrange, 0);
    reset  = 1'b0;
    start  = 1'b0;
    mode   = 1'b0;
    cmp_in = '0;
    for (int k = 0; k < 100; k++) begin
      clk_step();
      check("idle_busy", busy, 0);
      check("idle_pwm", pwm_out, 0);
    end

    plant_en  = 1'b1;
    prev_code = 0;
    hi_cnt    = 0;
    duty_en   = 1'b1;

    do_sweep(5, 9, 1'b0, 1, 1'b0, "normal");
    do_sweep(0, MAXC + 1, 1'b0, 1, 1'b0, "overrange");
    do_sweep(3, 12, 1'b1, 3, 1'b0, "continuous");
    do_sweep(MAXC, 7, 1'b0, 1, 1'b1, "start_ignored");
    for (int r = 0; r < 5; r++) begin
      do_sweep(int'($urandom_range(0, MAXC + 1)), int'($urandom_range(0, MAXC + 1)),
               1'b0, 1, 1'($urandom_range(0, 1)), "random");
    end

    // Abort mid-sweep at code 7 with reset.
    level[0] = MAXC + 1;
    level[1] = MAXC + 1;
    mode  = 1'b0;
    start = 1'b1;
    clk_step();
    start   = 1'b0;
    strobes = 0;
    for (int cyc = 1; cyc <= STEP * 8 + STEP / 2; cyc++) begin
      clk_step();
      if (result_valid) strobes++;
    end
    check("abort_code", ramp_code, 7);
    check("abort_no_strobe_before", strobes, 0);
    duty_en = 1'b0;
    reset   = 1'b1;
    clk_step();
    reset = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_result_valid", result_valid, 0);
    check("abort_ramp_code", ramp_code, 0);
    check("abort_result", result, 0);
    check("abort_overrange", overrange, 0);
    strobes = 0;
    for (int k = 0; k < 3 * STEP; k++) begin
      clk_step();
      if (result_valid || busy) strobes++;
    end
    check("abort_quiet", strobes, 0);
    prev_code = int'(ramp_code);
    hi_cnt    = 0;
    duty_en   = 1'b1;
    do_sweep(int'($urandom_range(0, MAXC)), int'($urandom_range(0, MAXC + 1)),
             1'b0, 1, 1'b0, "after_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
